// File: rtl/count_arb.sv
// Two-requester round-robin arbiter that owns a modulo-(MAXV+1) counter.
// A granted job presets the counter and performs len increments.
module count_arb #(
   parameter int unsigned MAXV = 211
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [8:0] start0,
   input  logic [8:0] start1,
   input  logic [8:0] len0,
   input  logic [8:0] len1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       busy,
   output logic       done0,
   output logic       done1,
   output logic [8:0] cnt,
   output logic       wrap
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [8:0] MAX9   = 9'(MAXV);

   logic [1:0] state_q, state_d;
   logic       owner_q, owner_d;
   logic       ptr_q, ptr_d;
   logic [8:0] start_q, start_d;
   logic [8:0] len_q, len_d;
   logic [8:0] cnt_q, cnt_d;
   logic [8:0] rem_q, rem_d;
   logic       wrap_q, wrap_d;
   logic       win;
   logic       owner_req;

   // Both requesting: the one not served last time wins.
   assign win       = (req0 && req1) ? ~ptr_q : req1;
   assign owner_req = owner_q ? req1 : req0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      start_d = start_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      wrap_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_LOAD;
               owner_d = win;
               start_d = win ? start1 : start0;
               len_d   = win ? len1 : len0;
            end
         end
         S_LOAD: begin
            if (!owner_req) begin
               state_d = S_IDLE;
               ptr_d   = owner_q;
            end else begin
               cnt_d   = (start_q > MAX9) ? 9'd0 : start_q;
               rem_d   = len_q;
               state_d = (len_q == 9'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (!owner_req) begin
               state_d = S_IDLE;
               ptr_d   = owner_q;
            end else begin
               cnt_d  = (cnt_q == MAX9) ? 9'd0 : cnt_q + 9'd1;
               wrap_d = (cnt_q == MAX9);
               rem_d  = rem_q - 9'd1;
               if (rem_q == 9'd1) state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            ptr_d   = owner_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         ptr_q   <= 1'b1;
         start_q <= 9'd0;
         len_q   <= 9'd0;
         cnt_q   <= 9'd0;
         rem_q   <= 9'd0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         start_q <= start_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         wrap_q  <= wrap_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign gnt0  = busy && !owner_q;
   assign gnt1  = busy && owner_q;
   assign done0 = (state_q == S_DONE) && !owner_q;
   assign done1 = (state_q == S_DONE) && owner_q;
   assign cnt   = cnt_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_count_arb.sv
// Directed-vector bench for count_arb; a negedge monitor checks done/wrap
// pulses against a queue of expected completions filled by the stimulus.
module tb_count_arb;

   localparam int MAXV = 211;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1;
   logic [8:0] start0, start1, len0, len1;
   logic       gnt0, gnt1, busy, done0, done1, wrap;
   logic [8:0] cnt;

   typedef struct packed {
      logic       who;
      logic [8:0] c;
   } exp_t;

   exp_t exp_q[$];
   int   exp_wrap = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   count_arb #(.MAXV(MAXV)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1),
      .start0(start0), .start1(start1),
      .len0(len0), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
      .done0(done0), .done1(done1),
      .cnt(cnt), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: pops an expectation for every done pulse, tracks wrap pulses.
   always @(negedge clk) begin
      exp_t e;
      if (gnt0 === 1'b1 && gnt1 === 1'b1) chk("gnt_exclusive", 1, 0);
      if (done0 === 1'b1 || done1 === 1'b1) begin
         if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("done_owner", int'(done1), int'(e.who));
            chk("done_cnt", int'(cnt), int'(e.c));
         end
      end
      if (wrap === 1'b1) begin
         chk("wrap_expected", int'(exp_wrap > 0), 1);
         if (exp_wrap > 0) exp_wrap--;
         chk("wrap_cnt", int'(cnt), 0);
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Single job for one requester; checks grant length, count sequence and hold.
   task automatic run_job(input logic who, input int st, input int ln,
                          input int exp_cnt, input int n_wrap);
      int g, t, base;
      exp_q.push_back('{who: who, c: 9'(exp_cnt)});
      exp_wrap += n_wrap;
      base = (st > MAXV) ? 0 : st;
      @(negedge clk);
      if (who) begin req1 = 1'b1; start1 = 9'(st); len1 = 9'(ln); end
      else     begin req0 = 1'b1; start0 = 9'(st); len0 = 9'(ln); end
      g = 0; t = 0;
      do begin
         @(negedge clk);
         t++;
         if ((who ? gnt1 : gnt0) === 1'b1) begin
            g++;
            // Late changes to the job parameters must be ignored.
            if (who) begin start1 = 9'h1AA; len1 = 9'h005; end
            else     begin start0 = 9'h1AA; len0 = 9'h005; end
            if (g >= 2) chk("job_cnt_seq", int'(cnt), (base + g - 2) % (MAXV + 1));
         end
      end while ((who ? done1 : done0) !== 1'b1 && t < ln + 10);
      req0 = 1'b0; req1 = 1'b0;
      chk("job_gnt_cycles", g, ln + 2);
      @(negedge clk);
      chk("job_idle_after", int'(busy), 0);
      chk("job_cnt_hold", int'(cnt), exp_cnt);
   endtask

   initial begin
      int jobs, pb, t;
      bit fin, seen;
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      start0 = '0; start1 = '0; len0 = '0; len1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt0", int'(gnt0), 0);
      chk("rst_gnt1", int'(gnt1), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done0 | done1), 0);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_cnt", int'(cnt), 0);
      reset = 1'b1;

      run_job(1'b0, 5, 3, 8, 0);
      run_job(1'b0, 210, 4, 2, 1);
      run_job(1'b1, 77, 0, 77, 0);

      // Both requesting continuously: strict alternation starting with req0.
      reset_dut();
      for (int k = 0; k < 6; k++)
         exp_q.push_back('{who: k[0], c: (k % 2) ? 9'd21 : 9'd11});
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; start0 = 9'd10; start1 = 9'd20; len0 = 9'd1; len1 = 9'd1;
      jobs = 0; pb = 0; fin = 1'b0;
      for (int i = 0; i < 60 && !fin; i++) begin
         @(negedge clk);
         if (busy === 1'b1 && pb == 0) begin
            chk("alt_owner", int'(gnt1), jobs % 2);
            jobs++;
         end
         if ((done0 === 1'b1 || done1 === 1'b1) && jobs == 6) begin
            req0 = 1'b0; req1 = 1'b0; fin = 1'b1;
         end
         pb = int'(busy === 1'b1);
      end
      chk("alt_jobs", jobs, 6);
      @(negedge clk);

      // Abort of a long job; the pending requester takes over.
      reset_dut();
      exp_q.push_back('{who: 1'b1, c: 9'd52});
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; start0 = 9'd0; len0 = 9'd100; start1 = 9'd50; len1 = 9'd2;
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(negedge clk);
         seen = (gnt0 === 1'b1);
      end
      chk("abort_gnt0", int'(seen), 1);
      repeat (5) @(negedge clk);
      chk("abort_cnt_run", int'(cnt), 4);
      req0 = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_gnt0_low", int'(gnt0), 0);
      chk("abort_cnt_hold", int'(cnt), 4);
      @(negedge clk);
      chk("abort_gnt1", int'(gnt1), 1);
      t = 0;
      while (done1 !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      chk("abort_next_done", int'(done1), 1);
      req1 = 1'b0;
      @(negedge clk);

      // Reset in the middle of a job, then an out-of-range preset.
      @(negedge clk);
      req0 = 1'b1; start0 = 9'd5; len0 = 9'd50;
      repeat (4) @(negedge clk);
      chk("mid_rst_running", int'(gnt0), 1);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_cnt", int'(cnt), 0);
      chk("mid_rst_gnt0", int'(gnt0), 0);
      chk("mid_rst_busy", int'(busy), 0);
      req0 = 1'b0; reset = 1'b1;
      run_job(1'b0, 7, 2, 9, 0);
      run_job(1'b0, 300, 0, 0, 0);

      repeat (3) @(negedge clk);
      chk("pending_done", exp_q.size(), 0);
      chk("pending_wrap", exp_wrap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/count_arb.md
COUNT_ARB -- requirements
Module: count_arb

Interface
REQ-001 Parameter MAXV, default 211, is the terminal count; the counter wraps MAXV -> 0 (modulus MAXV+1).
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 req0, req1  input  1 each  requester wants a counting job; must be held for the whole job.
REQ-005 start0, start1  input  9 each  counter preset value for each requester's job.
REQ-006 len0, len1  input  9 each  number of increments for each requester's job.
REQ-007 gnt0, gnt1  output  1 each  requester owns the counter; at most one is high.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 done0, done1  output  1 each  one-cycle pulse when the owner's job completes normally.
REQ-010 cnt  output  9  current counter value.
REQ-011 wrap  output  1  one-cycle pulse in the cycle after a MAXV -> 0 increment.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-013 In IDLE with any req high, the next edge SHALL enter LOAD, latch owner, and latch the owner's start and len; with no req, stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: a single requester wins; if both request, the winner is the one not equal to last-served pointer ptr.
REQ-015 req, start and len SHALL be sampled only in IDLE; changes to start or len later SHALL not affect the running job.
REQ-016 gnt of the owner SHALL be high in LOAD, RUN and DONE, and low in IDLE.
REQ-017 LOAD edge: cnt <= latched start, rem <= latched len; if start > MAXV, cnt <= 0.
REQ-018 LOAD edge: next state SHALL be DONE if len == 0, else RUN.
REQ-019 RUN edge: cnt <= (cnt == MAXV) ? 0 : cnt+1 and rem <= rem-1; enter DONE when rem == 1.
REQ-020 cnt SHALL change only on LOAD and RUN edges and hold its value in IDLE and DONE.
REQ-021 The job SHALL perform exactly len increments; the owner's done is high during the single DONE cycle.
REQ-022 Latency: with req sampled at edge E, done SHALL be visible after edge E+len+2.
REQ-023 The DONE edge SHALL return to IDLE and set ptr <= owner.
REQ-024 At least one IDLE cycle SHALL separate consecutive jobs.
REQ-025 Abort: if the owner's req is low in LOAD or RUN, the next edge SHALL go to IDLE with no done pulse.
REQ-026 On abort, ptr <= owner, cnt holds its last value, and gnt drops.
REQ-027 wrap SHALL be registered: high for one cycle after a RUN edge that took cnt from MAXV to 0; LOAD never asserts wrap.
REQ-028 The non-owner's req has no effect until the FSM is back in IDLE.

Reset
REQ-029 While reset is low at an edge: state=IDLE, cnt=0, rem=0, ptr=1, gnt0=gnt1=0, done0=done1=0, wrap=0.
REQ-030 Reset SHALL override every other event, including mid-job; no done pulse is emitted for the interrupted job.
REQ-031 After reset, req0 wins the first simultaneous request.

Verification
REQ-032 Reset, then req0=1, start0=5, len0=3 -> gnt0 is high for 5 cycles; cnt goes 5,6,7,8; done0 pulses once after edge E+5; cnt then holds 8.
REQ-033 start0=210, len0=4 -> cnt goes 210,211,0,1,2; wrap pulses once, in the cycle after the 211 -> 0 edge.
REQ-034 req0 and req1 held high continuously, len=1 each -> grants alternate gnt0, gnt1, gnt0, ... with one IDLE cycle between jobs and never both high.
REQ-035 len1=0 -> LOAD goes directly to DONE; done1 pulses 2 cycles after grant sampling; cnt equals start1.
REQ-036 Drop req0 in the middle of RUN with len0=100 -> next cycle state is IDLE, gnt0=0, no done0; a pending req1 is granted on the following edge.
REQ-037 Assert reset low during RUN -> next cycle cnt=0 and gnt=0, with no done; start0=300 after reset -> cnt loads 0.
